// File: rtl/serial_sub_32_bit.sv
// Bit-serial 32-bit subtractor: one full-adder cell plus a carry flop computes
// a + ~b + 1 LSB first over 32 cycles, then reports diff, borrow and overflow.
module serial_sub_32_bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] diff,
    output logic        borrow,
    output logic        ovf
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_sr;
    logic [W-1:0]    nb_sr;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic            a_sign;
    logic            b_sign;
    logic            accept;
    logic            last_bit;
    logic            sum_bit;
    logic            carry_nxt;

    // A new operation is taken from IDLE or straight out of DONE; RUN ignores start.
    assign accept    = start && (state != RUN);
    assign last_bit  = (state == RUN) && (cnt == CW'(W - 1));
    assign sum_bit   = a_sr[0] ^ nb_sr[0] ^ carry;
    assign carry_nxt = (a_sr[0] & nb_sr[0]) | (a_sr[0] & carry) | (nb_sr[0] & carry);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decode directly from the state flops
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Serial datapath: operand shift registers, carry, bit counter and results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            nb_sr  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            nb_sr  <= ~b;
            cnt    <= '0;
            carry  <= 1'b1;
            a_sign <= a[W-1];
            b_sign <= b[W-1];
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == RUN) begin
            diff  <= {sum_bit, diff[W-1:1]};
            a_sr  <= {1'b0, a_sr[W-1:1]};
            nb_sr <= {1'b0, nb_sr[W-1:1]};
            carry <= carry_nxt;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                borrow <= ~carry_nxt;
                ovf    <= (a_sign != b_sign) && (sum_bit != a_sign);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_32_bit.sv
// Self-checking bench for serial_sub_32_bit: directed cases, reset abort,
// back-to-back operation and randomized operands against an a - b model.
module tb_serial_sub_32_bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    serial_sub_32_bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain two's-complement subtraction
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        logic        br;
        logic        ov;
        d  = x - y;
        br = (x < y);
        ov = (x[31] != y[31]) && (d[31] != x[31]);
        return {ov, br, d};
    endfunction

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (diff !== 32'h0)  begin errors++; $display("FAIL reset_diff got=%h exp=0", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
        checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done);
        end
    endtask

    // One complete operation with junk on a/b while running
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input string name);
        logic [33:0] exp_v;
        int          lat;
        exp_v = model(oa, ob);
        @(negedge clk);
        start = 1'b1; a = oa; b = ob;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b exp=1", name, busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            a = $urandom; b = $urandom;
            lat++;
        end
        checks++; if (lat !== 32) begin errors++; $display("FAIL %s_latency got=%0d exp=32", name, lat); end
        checks++; if (diff !== exp_v[31:0]) begin
            errors++; $display("FAIL %s_diff a=%h b=%h got=%h exp=%h", name, oa, ob, diff, exp_v[31:0]);
        end
        checks++; if (borrow !== exp_v[32]) begin
            errors++; $display("FAIL %s_borrow a=%h b=%h got=%b exp=%b", name, oa, ob, borrow, exp_v[32]);
        end
        checks++; if (ovf !== exp_v[33]) begin
            errors++; $display("FAIL %s_ovf a=%h b=%h got=%b exp=%b", name, oa, ob, ovf, exp_v[33]);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || diff !== exp_v[31:0]) begin
            errors++; $display("FAIL %s_hold done=%b busy=%b diff=%h exp=0/0/%h", name, done, busy, diff, exp_v[31:0]);
        end
    endtask

    task automatic test_directed();
        run_op(32'd5, 32'd3, "sub_5_3");
        run_op(32'd3, 32'd5, "sub_3_5");
        run_op(32'h8000_0000, 32'h0000_0001, "ovf_neg");
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, "ovf_pos");
    endtask

    task automatic test_ignore_start();
        int lat;
        int pulses;
        @(negedge clk);
        start = 1'b1; a = 32'h1234_5678; b = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        pulses = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 10) begin start = 1'b1; a = 32'd1; b = 32'd0; end
            if (lat == 11) start = 1'b0;
        end
        checks++; if (lat !== 32) begin errors++; $display("FAIL ign_latency got=%0d exp=32", lat); end
        checks++; if (diff !== 32'h0 || borrow !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL ign_result diff=%h borrow=%b ovf=%b exp=0/0/0", diff, borrow, ovf);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL ign_extra_done got=%0d exp=0", pulses); end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        @(negedge clk);
        start = 1'b1; a = 32'd100; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_status busy=%b done=%b exp=0/0", busy, done);
        end
        checks++; if (diff !== 32'h0 || borrow !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL abort_outputs diff=%h borrow=%b ovf=%b exp=0/0/0", diff, borrow, ovf);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", pulses); end
        run_op(32'd0, 32'd1, "after_abort");
    endtask

    task automatic test_back_to_back();
        int cyc;
        int t1;
        @(negedge clk);
        start = 1'b1; a = 32'd10; b = 32'd4;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        t1 = cyc;
        checks++; if (done !== 1'b1 || diff !== 32'd6) begin
            errors++; $display("FAIL b2b_first done=%b diff=%h exp=1/00000006", done, diff);
        end
        a = 32'd4; b = 32'd10;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_handoff done=%b busy=%b exp=0/1", done, busy);
        end
        while (done !== 1'b1 && cyc < 90) begin @(negedge clk); cyc++; end
        checks++; if (cyc - t1 !== 33) begin errors++; $display("FAIL b2b_spacing got=%0d exp=33", cyc - t1); end
        checks++; if (diff !== 32'hFFFF_FFFA || borrow !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL b2b_second diff=%h borrow=%b ovf=%b exp=fffffffa/1/0", diff, borrow, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        for (int n = 0; n < 1200; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'h8000_0000;
                2: rb = ra;
                3: ra = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ra, rb, "rand");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
